// File: rtl/sram_rd_streamer_if.sv
// SRAM read port and output word stream of the burst read streamer.
// The master side is the streamer; the slave side is the SRAM plus stream sink.
interface sram_rd_streamer_if;
    logic        enb;
    logic [13:0] addrb;
    logic [63:0] doutb;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;

    modport master (output enb, addrb, m_valid, m_data, m_last, input doutb, m_ready);
    modport slave  (input enb, addrb, m_valid, m_data, m_last, output doutb, m_ready);
endinterface

// File: rtl/sram_rd_streamer.sv
// Burst reader: issues len word reads from a 1-cycle-latency SRAM starting at base_addr
// and streams the words out through a 2-entry FIFO with valid/ready flow control.
module sram_rd_streamer (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [13:0]        base_addr,
    input  logic [14:0]        len,
    output logic               busy,
    output logic               done,
    sram_rd_streamer_if.master bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_r;
    state_t      state_s;
    logic [14:0] rem_r;
    logic [13:0] addr_r;
    logic        pend_r;
    logic        pend_last_r;
    logic [1:0]  cnt_r;
    logic [63:0] d0_r;
    logic [63:0] d1_r;
    logic        l0_r;
    logic        l1_r;
    logic        done_r;
    logic        accept_s;
    logic        pop_s;
    logic        final_s;
    logic        enb_s;
    logic        busy_s;
    logic [2:0]  occ_s;

    assign accept_s = (state_r == IDLE) && start;
    assign pop_s    = (cnt_r != 2'd0) && bus.m_ready;
    assign final_s  = pop_s && l0_r;
    // Words held or already promised to the FIFO once this cycle's pop is taken out.
    assign occ_s    = {1'b0, cnt_r} + {2'b00, pend_r} - {2'b00, pop_s};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && (len != 15'd0)) state_s = RUN;
                else                         state_s = IDLE;
            end
            RUN: begin
                if (final_s) state_s = IDLE;
                else         state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // State-decoded outputs; a read goes out only if its word is sure to find FIFO room.
    always_comb begin
        enb_s  = 1'b0;
        busy_s = 1'b0;
        case (state_r)
            IDLE: begin
                enb_s  = 1'b0;
                busy_s = 1'b0;
            end
            RUN: begin
                busy_s = 1'b1;
                if (!rst && (rem_r != 15'd0) && (occ_s < 3'd2)) enb_s = 1'b1;
                else                                           enb_s = 1'b0;
            end
            default: begin
                enb_s  = 1'b0;
                busy_s = 1'b0;
            end
        endcase
    end

    // Burst parameters: capture on accept, then step once per issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r  <= 15'd0;
            addr_r <= 14'd0;
        end else if (accept_s) begin
            rem_r  <= len;
            addr_r <= base_addr;
        end else if (enb_s) begin
            rem_r  <= rem_r - 15'd1;
            addr_r <= addr_r + 14'd1;
        end else begin
            rem_r  <= rem_r;
            addr_r <= addr_r;
        end
    end

    // In-flight read tracking and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= 1'b0;
            pend_last_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            pend_r      <= enb_s;
            pend_last_r <= enb_s && (rem_r == 15'd1);
            done_r      <= (accept_s && (len == 15'd0)) || ((state_r == RUN) && final_s);
        end
    end

    // Two-entry output FIFO; entry 0 is the head presented on the stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 2'd0;
            d0_r  <= 64'd0;
            d1_r  <= 64'd0;
            l0_r  <= 1'b0;
            l1_r  <= 1'b0;
        end else begin
            case ({pend_r, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        d0_r  <= bus.doutb;
                        l0_r  <= pend_last_r;
                        cnt_r <= 2'd1;
                    end else begin
                        d1_r  <= bus.doutb;
                        l1_r  <= pend_last_r;
                        cnt_r <= 2'd2;
                    end
                end
                2'b01: begin
                    d0_r  <= d1_r;
                    l0_r  <= l1_r;
                    cnt_r <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        d0_r <= bus.doutb;
                        l0_r <= pend_last_r;
                    end else begin
                        d0_r <= d1_r;
                        l0_r <= l1_r;
                        d1_r <= bus.doutb;
                        l1_r <= pend_last_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.enb     = enb_s;
    assign bus.addrb   = addr_r;
    assign bus.m_valid = (cnt_r != 2'd0);
    assign bus.m_data  = d0_r;
    assign bus.m_last  = l0_r && (cnt_r != 2'd0);
    assign busy        = busy_s;
    assign done        = done_r;
endmodule

// File: tb/tb_sram_rd_streamer.sv
// Directed bench for sram_rd_streamer: SRAM model returns a word derived from its address,
// a negedge monitor logs reads, transfers and done pulses for the scenario tasks to check.
module tb_sram_rd_streamer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] len;
    logic        busy;
    logic        done;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    sram_rd_streamer_if bus ();

    sram_rd_streamer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_word(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a, 16'h5A5A, 2'b11, ~a};
    endfunction

    always @(posedge clk) begin
        if (bus.enb) bus.doutb <= mem_word(bus.addrb);
    end

    logic [13:0] addr_q[$];
    int          enb_cyc_q[$];
    logic [63:0] rx_q[$];
    logic        last_q[$];
    int          rx_cyc_q[$];
    int          done_q[$];
    int          iss_tot, pop_tot, max_out, busy_cnt, done_busy, stall_viol;
    int          idle_enb = 0;
    int          last_viol = 0;
    logic        hold_p = 1'b0;
    logic [63:0] data_p = 64'd0;
    logic        last_p = 1'b0;

    always @(negedge clk) begin
        if (bus.enb) begin
            addr_q.push_back(bus.addrb);
            enb_cyc_q.push_back(cyc);
            iss_tot++;
            if (!busy) idle_enb++;
        end
        if (bus.m_valid && bus.m_ready) begin
            rx_q.push_back(bus.m_data);
            last_q.push_back(bus.m_last);
            rx_cyc_q.push_back(cyc);
            pop_tot++;
        end
        if (bus.m_last && !bus.m_valid) last_viol++;
        if (hold_p && (!bus.m_valid || bus.m_data !== data_p || bus.m_last !== last_p)) stall_viol++;
        hold_p = bus.m_valid && !bus.m_ready;
        data_p = bus.m_data;
        last_p = bus.m_last;
        if (iss_tot - pop_tot > max_out) max_out = iss_tot - pop_tot;
        if (busy) busy_cnt++;
        if (done) begin
            done_q.push_back(cyc);
            if (busy) done_busy++;
        end
    end

    task automatic clear_mon();
        addr_q.delete(); enb_cyc_q.delete(); rx_q.delete(); last_q.delete();
        rx_cyc_q.delete(); done_q.delete();
        iss_tot = 0; pop_tot = 0; max_out = 0; busy_cnt = 0; done_busy = 0; stall_viol = 0;
    endtask

    // Called just after a posedge; start is high for exactly one cycle t, then inputs are scrambled.
    task automatic do_start(input logic [13:0] b, input logic [14:0] l, output int t);
        start = 1'b1; base_addr = b; len = l; t = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = ~b; len = 15'h7FFF;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (done_q.size() < n) begin
            errors++; $display("FAIL %s_timeout: done pulses %0d, required %0d", name, done_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = 14'd0; len = 15'd0; bus.m_ready = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.enb !== 1'b0) begin errors++; $display("FAIL reset_enb: got %0b required 0", bus.enb); end
        checks++; if (bus.addrb !== 14'd0) begin errors++; $display("FAIL reset_addrb: got %h required 0", bus.addrb); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b required 0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %0b required 0", bus.m_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b required 0", done); end
        // start in a reset cycle must be dropped
        start = 1'b1; len = 15'd5; base_addr = 14'h0055;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || addr_q.size() != 0 || done_q.size() != 0) begin
            errors++; $display("FAIL reset_priority: busy %0b reads %0d dones %0d, required 0 0 0", busy, addr_q.size(), done_q.size());
        end
    endtask

    task automatic test_basic();
        int t;
        clear_mon(); bus.m_ready = 1'b1;
        do_start(14'h0010, 15'd4, t);
        wait_done(1, 50, "basic");
        repeat (2) @(posedge clk);
        #1;
        checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL basic_reads: got %0d required 4", addr_q.size()); end
        for (int i = 0; i < addr_q.size() && i < 4; i++) begin
            checks++;
            if (addr_q[i] !== 14'(32'h10 + i) || enb_cyc_q[i] != t + 1 + i) begin
                errors++; $display("FAIL basic_read%0d: addr %h cyc %0d, required %h %0d", i, addr_q[i], enb_cyc_q[i], 14'(32'h10 + i), t + 1 + i);
            end
        end
        checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d required 4", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 4; i++) begin
            checks++;
            if (rx_q[i] !== mem_word(14'(32'h10 + i)) || last_q[i] !== (i == 3) || rx_cyc_q[i] != t + 3 + i) begin
                errors++; $display("FAIL basic_word%0d: data %h last %0b cyc %0d, required %h %0b %0d", i, rx_q[i], last_q[i], rx_cyc_q[i], mem_word(14'(32'h10 + i)), (i == 3), t + 3 + i);
            end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != t + 7) begin errors++; $display("FAIL basic_done: pulses %0d first cyc %0d, required 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t + 7); end
        checks++; if (busy_cnt != 6 || done_busy != 0) begin errors++; $display("FAIL basic_busy: busy cycles %0d busy-at-done %0d, required 6 0", busy_cnt, done_busy); end
    endtask

    task automatic test_wrap();
        int t;
        logic [13:0] exp_a[4];
        exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
        clear_mon(); bus.m_ready = 1'b1;
        do_start(14'h3FFE, 15'd4, t);
        wait_done(1, 50, "wrap");
        #1;
        checks++; if (addr_q.size() != 4 || rx_q.size() != 4) begin errors++; $display("FAIL wrap_count: reads %0d words %0d, required 4 4", addr_q.size(), rx_q.size()); end
        for (int i = 0; i < addr_q.size() && i < rx_q.size() && i < 4; i++) begin
            checks++;
            if (addr_q[i] !== exp_a[i] || rx_q[i] !== mem_word(exp_a[i]) || last_q[i] !== (i == 3)) begin
                errors++; $display("FAIL wrap_word%0d: addr %h data %h last %0b, required %h %h %0b", i, addr_q[i], rx_q[i], last_q[i], exp_a[i], mem_word(exp_a[i]), (i == 3));
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        logic pat[6];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
        clear_mon(); bus.m_ready = 1'b1;
        do_start(14'h0100, 15'd8, t);
        for (int k = 0; k < 300 && done_q.size() == 0; k++) begin
            bus.m_ready = pat[k % 6];
            @(posedge clk); #1;
        end
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d required 8", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            checks++;
            if (rx_q[i] !== mem_word(14'(32'h100 + i)) || last_q[i] !== (i == 7)) begin
                errors++; $display("FAIL bp_word%0d: data %h last %0b, required %h %0b", i, rx_q[i], last_q[i], mem_word(14'(32'h100 + i)), (i == 7));
            end
        end
        checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: got %0d required <= 2", max_out); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_hold: unstable stalled cycles %0d required 0", stall_viol); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL bp_done: pulses %0d required 1", done_q.size()); end
    endtask

    task automatic test_zero_len();
        int t;
        clear_mon(); bus.m_ready = 1'b1;
        do_start(14'h0123, 15'd0, t);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (done_q.size() != 1 || done_q[0] != t + 1) begin errors++; $display("FAIL zero_done: pulses %0d first cyc %0d, required 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t + 1); end
        checks++; if (addr_q.size() != 0 || busy_cnt != 0) begin errors++; $display("FAIL zero_quiet: reads %0d busy cycles %0d, required 0 0", addr_q.size(), busy_cnt); end
    endtask

    task automatic test_ignored_start();
        int t, t2;
        clear_mon(); bus.m_ready = 1'b1;
        do_start(14'h0200, 15'd5, t);
        @(posedge clk); #1;
        do_start(14'h0300, 15'd2, t2);
        wait_done(1, 60, "ignored");
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_q.size() != 5 || addr_q.size() != 5) begin errors++; $display("FAIL ign_count: words %0d reads %0d, required 5 5", rx_q.size(), addr_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            checks++;
            if (rx_q[i] !== mem_word(14'(32'h200 + i)) || last_q[i] !== (i == 4)) begin
                errors++; $display("FAIL ign_word%0d: data %h last %0b, required %h %0b", i, rx_q[i], last_q[i], mem_word(14'(32'h200 + i)), (i == 4));
            end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != t + 8) begin errors++; $display("FAIL ign_done: pulses %0d first cyc %0d, required 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t + 8); end
    endtask

    task automatic test_back_to_back();
        int t, t2;
        logic [13:0] exp_a[5];
        exp_a[0] = 14'h0040; exp_a[1] = 14'h0041; exp_a[2] = 14'h0050; exp_a[3] = 14'h0051; exp_a[4] = 14'h0052;
        clear_mon(); bus.m_ready = 1'b1;
        do_start(14'h0040, 15'd2, t);
        repeat (4) @(posedge clk);
        #1;
        do_start(14'h0050, 15'd3, t2);
        wait_done(2, 60, "b2b");
        #1;
        checks++; if (done_q.size() != 2 || done_q[0] != t + 5 || done_q[1] != t2 + 6) begin
            errors++; $display("FAIL b2b_done: pulses %0d cycles %0d %0d, required 2 at %0d %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, (done_q.size() > 1) ? done_q[1] : -1, t + 5, t2 + 6);
        end
        checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d required 5", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            checks++;
            if (rx_q[i] !== mem_word(exp_a[i]) || last_q[i] !== (i == 1 || i == 4)) begin
                errors++; $display("FAIL b2b_word%0d: data %h last %0b, required %h %0b", i, rx_q[i], last_q[i], mem_word(exp_a[i]), (i == 1 || i == 4));
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, n_rd;
        clear_mon(); bus.m_ready = 1'b1;
        do_start(14'h0080, 15'd10, t);
        for (int k = 0; k < 40 && rx_q.size() < 3; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_rd = addr_q.size();
        checks++;
        if (bus.enb !== 1'b0 || bus.addrb !== 14'd0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: enb %0b addrb %h valid %0b last %0b busy %0b done %0b, required all 0", bus.enb, bus.addrb, bus.m_valid, bus.m_last, busy, done);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (done_q.size() != 0 || addr_q.size() != n_rd) begin errors++; $display("FAIL mid_reset_quiet: dones %0d reads %0d, required 0 %0d", done_q.size(), addr_q.size(), n_rd); end
        clear_mon();
        do_start(14'h0090, 15'd2, t);
        wait_done(1, 40, "mid_restart");
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL mid_restart_count: got %0d required 2", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 2; i++) begin
            checks++;
            if (rx_q[i] !== mem_word(14'(32'h90 + i)) || last_q[i] !== (i == 1)) begin
                errors++; $display("FAIL mid_restart_word%0d: data %h last %0b, required %h %0b", i, rx_q[i], last_q[i], mem_word(14'(32'h90 + i)), (i == 1));
            end
        end
    endtask

    task automatic test_full_len();
        int t;
        int bad = 0;
        clear_mon(); bus.m_ready = 1'b1;
        do_start(14'h0000, 15'd16384, t);
        wait_done(1, 17000, "full");
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_q.size() != 16384 || addr_q.size() != 16384) begin errors++; $display("FAIL full_count: words %0d reads %0d, required 16384 16384", rx_q.size(), addr_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i] !== mem_word(14'(i)) || last_q[i] !== (i == 16383)) bad++;
        end
        for (int i = 0; i < addr_q.size(); i++) begin
            if (addr_q[i] !== 14'(i)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_order: bad words/addresses %0d required 0", bad); end
        checks++; if (rx_q.size() != 16384 || rx_q[16383] !== mem_word(14'h3FFF) || last_q[16383] !== 1'b1) begin
            errors++; $display("FAIL full_last: final word/last flag wrong, words %0d", rx_q.size());
        end
        checks++; if (done_q.size() != 1 || done_q[0] != t + 16387) begin errors++; $display("FAIL full_done: pulses %0d first cyc %0d, required 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t + 16387); end
    endtask

    task automatic test_invariants();
        checks++; if (idle_enb != 0) begin errors++; $display("FAIL inv_idle_enb: got %0d required 0", idle_enb); end
        checks++; if (last_viol != 0) begin errors++; $display("FAIL inv_last_no_valid: got %0d required 0", last_viol); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 14'd0; len = 15'd0;
        bus.m_ready = 1'b0; bus.doutb = 64'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_full_len();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
